// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction memory and its byte loader.
// INST_BYTESWAP_EN selects little-endian byte placement within a word.
package inst_mem_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } state_t;

`ifdef INST_BYTESWAP_EN
   localparam bit BYTESWAP = 1'b1;
`else
   localparam bit BYTESWAP = 1'b0;
`endif

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Lane that the idx-th byte of a word occupies; lane i is word bits [8i+7:8i].
   function automatic int lane_of(input int idx, input int nbytes);
      return BYTESWAP ? idx : (nbytes - 1 - idx);
   endfunction

endpackage

// File: rtl/inst_word_assembler.sv
// Packs accepted program bytes into words; flags a finished word for one cycle
// and zero-pads lanes that were never filled.
module inst_word_assembler
   import inst_mem_pkg::*;
#(
   parameter  int NWORD_BYTES = 4,
   localparam int BC_BITS     = clog2(NWORD_BYTES) + 1,
   localparam int WORD_BITS   = 8 * NWORD_BYTES
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_in,
   input  logic                 byte_last,
   output logic                 word_done,
   output logic                 word_last,
   output logic [WORD_BITS-1:0] word_out
);

   logic [NWORD_BYTES-1:0][7:0] lanes_q, lanes_d;
   logic [BC_BITS-1:0]          bc_q, bc_d, bc_eff;
   logic                        done_q, done_d;
   logic                        last_q, last_d;

   // A finished word is consumed on the edge after it completes, so the next
   // byte may already arrive in that cycle and must start from a clean word.
   always_comb begin
      lanes_d = done_q ? '0 : lanes_q;
      bc_eff  = done_q ? '0 : bc_q;
      bc_d    = bc_eff;
      done_d  = 1'b0;
      last_d  = 1'b0;
      if (byte_valid) begin
         for (int i = 0; i < NWORD_BYTES; i++) begin
            if (i == lane_of(int'(bc_eff), NWORD_BYTES)) lanes_d[i] = byte_in;
         end
         bc_d   = bc_eff + 1'b1;
         done_d = (bc_d == BC_BITS'(NWORD_BYTES)) || byte_last;
         last_d = byte_last;
      end
      if (clear) begin
         lanes_d = '0;
         bc_d    = '0;
         done_d  = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lanes_q <= '0;
         bc_q    <= '0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         lanes_q <= lanes_d;
         bc_q    <= bc_d;
         done_q  <= done_d;
         last_q  <= last_d;
      end
   end

   assign word_done = done_q;
   assign word_last = last_q;
   assign word_out  = lanes_q;

endmodule

// File: rtl/inst_mem.sv
// Instruction memory loaded from a byte stream after reset, then read by PC.
// Byte order within a word follows INST_BYTESWAP_EN (see inst_mem_pkg).
//
// state | meaning
// LOAD  | accepting program bytes, writing each completed word at wp
// CLEAR | zero-filling mem[wp..DEPTH-1] after the program's last word
// RUN   | registered fetches from address; reload returns to LOAD
module inst_mem
   import inst_mem_pkg::*;
#(
   parameter  int NADDR_BITS  = 8,
   parameter  int NWORD_BYTES = 4,
   localparam int WORD_BITS   = 8 * NWORD_BYTES,
   localparam int OFS_BITS    = clog2(NWORD_BYTES),
   localparam int WP_BITS     = NADDR_BITS - OFS_BITS,
   localparam int DEPTH       = 1 << WP_BITS
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NADDR_BITS-1:0] address,
   output logic [WORD_BITS-1:0]  q,
   output logic                  q_valid,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [7:0]            ld_byte,
   input  logic                  ld_last,
   input  logic                  reload,
   output logic                  busy,
   output logic                  overflow
);

   state_t               state_q, state_d;
   logic [WP_BITS-1:0]   wp_q, wp_d;
   logic                 overflow_q, overflow_d;
   logic [WORD_BITS-1:0] q_q;
   logic                 q_valid_q;

   logic                 mem_we;
   logic [WORD_BITS-1:0] mem_wdata;
   logic [WORD_BITS-1:0] mem [DEPTH];

   logic                 accept;
   logic                 restart;
   logic                 fetch_en;
   logic                 wp_at_end;
   logic                 word_done;
   logic                 word_last;
   logic [WORD_BITS-1:0] word_out;
   logic [WP_BITS-1:0]   rd_idx;

   assign accept    = ld_valid && ld_ready;
   assign restart   = (state_q == RUN) && reload;
   assign fetch_en  = (state_q == RUN) && !reload;
   assign wp_at_end = (wp_q == WP_BITS'(DEPTH - 1));
   assign rd_idx    = address[NADDR_BITS-1:OFS_BITS];

   if (OFS_BITS > 0) begin : g_ofs
      logic unused_ofs;
      assign unused_ofs = ^address[OFS_BITS-1:0];
   end

   inst_word_assembler #(
      .NWORD_BYTES (NWORD_BYTES)
   ) u_asm (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (restart),
      .byte_valid (accept),
      .byte_in    (ld_byte),
      .byte_last  (ld_last),
      .word_done  (word_done),
      .word_last  (word_last),
      .word_out   (word_out)
   );

   always_comb begin
      state_d    = state_q;
      wp_d       = wp_q;
      overflow_d = overflow_q;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      case (state_q)
         LOAD: begin
            if (word_done) begin
               mem_we    = 1'b1;
               mem_wdata = word_out;
               if (wp_at_end) begin
                  state_d = RUN;
                  if (!word_last) overflow_d = 1'b1;
               end else begin
                  wp_d = wp_q + 1'b1;
                  if (word_last) state_d = CLEAR;
               end
            end
         end
         CLEAR: begin
            mem_we = 1'b1;
            if (wp_at_end) state_d = RUN;
            else           wp_d    = wp_q + 1'b1;
         end
         RUN: begin
            if (reload) begin
               state_d = LOAD;
               wp_d    = '0;
            end
         end
         default: begin
            state_d = LOAD;
            wp_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= LOAD;
         wp_q       <= '0;
         overflow_q <= 1'b0;
         q_q        <= '0;
         q_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         overflow_q <= overflow_d;
         q_q        <= fetch_en ? mem[rd_idx] : '0;
         q_valid_q  <= fetch_en;
      end
   end

   // Storage has no reset; its contents are always rewritten by a full load.
   always_ff @(posedge clock) begin
      if (mem_we) mem[wp_q] <= mem_wdata;
   end

   assign q        = q_q;
   assign q_valid  = q_valid_q;
   assign ld_ready = (state_q == LOAD);
   assign busy     = (state_q != RUN);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: byte-stream loads, zero-fill timing, overflow,
// reload and asynchronous reset, with fetches checked through a scoreboard.
module tb_inst_mem;

   logic        clock;
   logic        reset_n;
   logic [7:0]  address;
   logic [31:0] q;
   logic        q_valid;
   logic        ld_valid;
   logic        ld_ready;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        reload;
   logic        busy;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } exp_t;
   exp_t sb[$];

   inst_mem dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .address  (address),
      .q        (q),
      .q_valid  (q_valid),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_byte  (ld_byte),
      .ld_last  (ld_last),
      .reload   (reload),
      .busy     (busy),
      .overflow (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
`ifdef INST_BYTESWAP_EN
      return {b3, b2, b1, b0};
`else
      return {b0, b1, b2, b3};
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      for (int i = 0; i < gap; i++) begin
         ld_valid = 1'b0;
         ld_byte  = 8'h5A;
         @(negedge clock);
      end
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      @(negedge clock);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_byte  = 8'h00;
   endtask

   task automatic wait_run(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clock);
         n++;
      end
      check(tag, n, exp_cycles);
   endtask

   task automatic fetch(input logic [7:0] a, input logic [31:0] e);
      exp_t x;
      address = a;
      sb.push_back('{a: a, d: e});
      @(negedge clock);
      x = sb.pop_front();
      check($sformatf("fetch@%h", x.a), q, x.d);
      check($sformatf("q_valid@%h", x.a), q_valid, 1);
   endtask

   task automatic do_reload();
      address = 8'h04;
      reload  = 1'b1;
      @(negedge clock);
      reload = 1'b0;
      check("reload q_valid", q_valid, 0);
      check("reload q", q, 0);
      check("reload ld_ready", ld_ready, 1);
      check("reload busy", busy, 1);
   endtask

   initial begin
      reset_n  = 1'b0;
      address  = 8'h00;
      ld_valid = 1'b0;
      ld_byte  = 8'h00;
      ld_last  = 1'b0;
      reload   = 1'b0;
      repeat (2) @(negedge clock);
      check("rst q", q, 0);
      check("rst q_valid", q_valid, 0);
      check("rst ld_ready", ld_ready, 1);
      check("rst busy", busy, 1);
      check("rst overflow", overflow, 0);
      reset_n = 1'b1;
      @(negedge clock);
      check("post-rst ld_ready", ld_ready, 1);

      // two-word program, back-to-back bytes
      send_byte(8'h13, 0, 0); send_byte(8'h00, 0, 0);
      send_byte(8'h00, 0, 0); send_byte(8'h00, 0, 0);
      send_byte(8'h93, 0, 0); send_byte(8'h00, 0, 0);
      send_byte(8'h10, 0, 0); send_byte(8'h00, 1, 0);
      check("load q_valid", q_valid, 0);
      @(negedge clock);
      check("clear ld_ready", ld_ready, 0);
      check("clear busy", busy, 1);
      wait_run("run after 2 words", 62);
      check("no overflow", overflow, 0);
      check("run ld_ready", ld_ready, 0);
      @(negedge clock);
      check("first q_valid", q_valid, 1);
      fetch(8'h00, pack(8'h13, 8'h00, 8'h00, 8'h00));
      fetch(8'h04, pack(8'h93, 8'h00, 8'h10, 8'h00));
      fetch(8'h07, pack(8'h93, 8'h00, 8'h10, 8'h00));
      fetch(8'h08, 32'h0);
      fetch(8'hFC, 32'h0);

      // reload, partial word, stalls in the stream
      do_reload();
      send_byte(8'hAA, 0, 1); send_byte(8'hBB, 0, 3);
      send_byte(8'hCC, 0, 0); send_byte(8'hDD, 0, 2);
      send_byte(8'hEE, 1, 1);
      wait_run("busy fall after partial", 63);
      fetch(8'h00, pack(8'hAA, 8'hBB, 8'hCC, 8'hDD));
      fetch(8'h04, pack(8'hEE, 8'h00, 8'h00, 8'h00));
      fetch(8'h08, 32'h0);

      // single-word program
      do_reload();
      send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
      send_byte(8'h03, 0, 0); send_byte(8'h04, 1, 0);
      wait_run("busy fall after 1 word", 64);
      fetch(8'h00, pack(8'h01, 8'h02, 8'h03, 8'h04));
      fetch(8'h04, 32'h0);

      // fill the whole memory without ld_last
      do_reload();
      for (int i = 0; i < 256; i++) send_byte(8'(i), 0, 0);
      wait_run("busy fall on overflow", 1);
      check("overflow set", overflow, 1);
      ld_valid = 1'b1;
      ld_byte  = 8'hFF;
      @(negedge clock);
      check("overflow ld_ready", ld_ready, 0);
      ld_valid = 1'b0;
      fetch(8'h00, pack(8'h00, 8'h01, 8'h02, 8'h03));
      fetch(8'h80, pack(8'h80, 8'h81, 8'h82, 8'h83));
      fetch(8'hFC, pack(8'hFC, 8'hFD, 8'hFE, 8'hFF));
      check("overflow ld_ready later", ld_ready, 0);

      // asynchronous reset in the middle of CLEAR
      do_reload();
      check("overflow sticky", overflow, 1);
      send_byte(8'h21, 0, 0); send_byte(8'h22, 0, 0);
      send_byte(8'h23, 0, 0); send_byte(8'h24, 1, 0);
      repeat (4) @(negedge clock);
      check("mid-clear ld_ready", ld_ready, 0);
      #2 reset_n = 1'b0;
      #1;
      check("async q", q, 0);
      check("async q_valid", q_valid, 0);
      check("async ld_ready", ld_ready, 1);
      check("async busy", busy, 1);
      check("async overflow", overflow, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      send_byte(8'h11, 0, 0); send_byte(8'h22, 1, 0);
      wait_run("busy fall after reset", 64);
      fetch(8'h00, pack(8'h11, 8'h22, 8'h00, 8'h00));
      fetch(8'h04, 32'h0);
      fetch(8'h00, pack(8'h11, 8'h22, 8'h00, 8'h00));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
